avmm_pio_poll_master: RTL and testbench

- Avalon-MM read-only master that periodically polls a PIO input-port slave and turns its data register into a debounced, change-flagged value for fabric logic.
- Sits between the HPS-side PIO slave and FPGA consumers that need change events rather than raw polled reads.
- Every poll is a single read with waitrequest handling and fixed read latency.
- Samples pass a stability filter; confirmed changes produce a one-cycle pulse with rise and fall masks.

---
 rtl/avmm_pio_pkg.sv | 22 ++
 rtl/pio_stable_filter.sv | 83 ++++++++
 rtl/avmm_pio_poll_master.sv | 133 +++++++++++++
 tb/tb_avmm_pio_poll_master.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/avmm_pio_pkg.sv
// Shared definitions for the Avalon-MM PIO poll master.
//   poll_state_t : poll FSM states (IDLE, REQ, WAIT, EVAL)
//   LAT_W        : width of the read-latency counter
//   STAB_W       : width of the stability counter
//   timer_width  : bits needed to hold POLL_DIV-1
package avmm_pio_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      EVAL = 2'd3
   } poll_state_t;

   localparam int LAT_W  = 3;
   localparam int STAB_W = 4;

   function automatic int timer_width(input int div);
      return (div > 2) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/pio_stable_filter.sv
// Stability filter for polled PIO samples. A sample must repeat STABLE_CNT
// times in a row before it becomes the published value; confirmed changes
// produce a one-cycle pulse with rise/fall masks.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   sample_valid    : one-cycle strobe, sample is evaluated this cycle
//   sample          : polled PIO bits
//   value           : debounced value
//   value_valid     : set on first accepted value
//   changed         : one-cycle pulse on an accepted change
//   rise_mask       : bits that went 0->1, valid with changed
//   fall_mask       : bits that went 1->0, valid with changed
module pio_stable_filter
   import avmm_pio_pkg::*;
#(
   parameter int WIDTH      = 3,
   parameter int STABLE_CNT = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] sample,
   output logic [WIDTH-1:0] value,
   output logic             value_valid,
   output logic             changed,
   output logic [WIDTH-1:0] rise_mask,
   output logic [WIDTH-1:0] fall_mask
);

   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CNT);

   logic [WIDTH-1:0]  candidate;
   logic [WIDTH-1:0]  cand_nxt;
   logic [STAB_W-1:0] stab_cnt;
   logic [STAB_W-1:0] cnt_nxt;
   logic              accept;

   // Saturating run-length count of identical samples; acceptance looks at
   // the post-update count so STABLE_CNT=1 accepts on the first differing sample.
   always_comb begin
      cand_nxt = candidate;
      cnt_nxt  = stab_cnt;
      if (sample == candidate) begin
         if (stab_cnt != STAB_MAX)
            cnt_nxt = stab_cnt + STAB_W'(1);
      end else begin
         cand_nxt = sample;
         cnt_nxt  = STAB_W'(1);
      end
      accept = (cnt_nxt == STAB_MAX) && (!value_valid || (cand_nxt != value));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         candidate   <= '0;
         stab_cnt    <= '0;
         value       <= '0;
         value_valid <= 1'b0;
         changed     <= 1'b0;
         rise_mask   <= '0;
         fall_mask   <= '0;
      end else begin
         changed   <= 1'b0;
         rise_mask <= '0;
         fall_mask <= '0;
         if (sample_valid) begin
            candidate <= cand_nxt;
            stab_cnt  <= cnt_nxt;
            if (accept) begin
               value       <= cand_nxt;
               value_valid <= 1'b1;
               // The very first acceptance has no meaningful "old" value.
               if (value_valid) begin
                  changed   <= 1'b1;
                  rise_mask <= cand_nxt & ~value;
                  fall_mask <= ~cand_nxt & value;
               end
            end
         end
      end
   end

endmodule

// File: rtl/avmm_pio_poll_master.sv
// Avalon-MM read-only master that polls a PIO data register every POLL_DIV
// cycles and feeds the low WIDTH bits through a stability filter.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   enable         : polling enable (level)
//   m_address      : constant PIO_ADDR
//   m_read         : read strobe, held until waitrequest drops
//   m_waitrequest  : slave stall
//   m_readdata     : slave read data (bits WIDTH and up ignored)
//   value, value_valid, changed, rise_mask, fall_mask : filter outputs
//   overrun        : sticky, a poll tick arrived while a read was in flight
module avmm_pio_poll_master
   import avmm_pio_pkg::*;
#(
   parameter int WIDTH        = 3,
   parameter int ADDR_W       = 2,
   parameter int PIO_ADDR     = 0,
   parameter int POLL_DIV     = 50000,
   parameter int READ_LATENCY = 1,
   parameter int STABLE_CNT   = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   output logic [ADDR_W-1:0] m_address,
   output logic              m_read,
   input  logic              m_waitrequest,
   input  logic [31:0]       m_readdata,
   output logic [WIDTH-1:0]  value,
   output logic              value_valid,
   output logic              changed,
   output logic [WIDTH-1:0]  rise_mask,
   output logic [WIDTH-1:0]  fall_mask,
   output logic              overrun
);

   localparam int              TW           = timer_width(POLL_DIV);
   localparam logic [TW-1:0]   TIMER_RELOAD = TW'(POLL_DIV - 1);
   localparam logic [LAT_W-1:0] LAT_LAST    = LAT_W'(READ_LATENCY);

   poll_state_t       state;
   poll_state_t       state_nxt;
   logic [TW-1:0]     timer;
   logic              tick;
   logic [LAT_W-1:0]  lat_cnt;
   logic [WIDTH-1:0]  sample_p0;
   logic              sample_valid;
   logic              data_last;
   logic              unused_readdata;

   assign m_address       = ADDR_W'(PIO_ADDR);
   assign unused_readdata = ^(m_readdata >> WIDTH);

   // Poll timer: held at reload while disabled, so re-enabling always
   // gives a full POLL_DIV period before the next launch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         timer <= TIMER_RELOAD;
      else if (!enable || (timer == '0))
         timer <= TIMER_RELOAD;
      else
         timer <= timer - TW'(1);
   end

   assign tick      = enable && (timer == '0);
   assign data_last = (lat_cnt == LAT_LAST);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (tick)           state_nxt = REQ;
         REQ:  if (!m_waitrequest) state_nxt = WAIT;
         WAIT: if (data_last)      state_nxt = EVAL;
         EVAL:                     state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      m_read       = (state == REQ);
      sample_valid = (state == EVAL);
   end

   // Latency counter starts at 1 in the first WAIT cycle, so the sample is
   // captured exactly READ_LATENCY cycles after acceptance.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lat_cnt   <= '0;
         sample_p0 <= '0;
      end else begin
         if ((state == REQ) && !m_waitrequest)
            lat_cnt <= LAT_W'(1);
         else if (state == WAIT)
            lat_cnt <= lat_cnt + LAT_W'(1);
         if ((state == WAIT) && data_last)
            sample_p0 <= m_readdata[WIDTH-1:0];
      end
   end

   // A tick outside IDLE is dropped, never queued.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         overrun <= 1'b0;
      else if (tick && (state != IDLE))
         overrun <= 1'b1;
   end

   pio_stable_filter #(
      .WIDTH      (WIDTH),
      .STABLE_CNT (STABLE_CNT)
   ) u_filter (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample_valid (sample_valid),
      .sample       (sample_p0),
      .value        (value),
      .value_valid  (value_valid),
      .changed      (changed),
      .rise_mask    (rise_mask),
      .fall_mask    (fall_mask)
   );

endmodule

// File: tb/tb_avmm_pio_poll_master.sv
// Directed testbench for avmm_pio_poll_master (POLL_DIV=8, READ_LATENCY=1,
// STABLE_CNT=2, WIDTH=3). The bench acts as the PIO slave by driving
// m_waitrequest and m_readdata directly.
module tb_avmm_pio_poll_master;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [1:0]  m_address;
   logic        m_read;
   logic        m_waitrequest;
   logic [31:0] m_readdata;
   logic [2:0]  value;
   logic        value_valid;
   logic        changed;
   logic [2:0]  rise_mask;
   logic [2:0]  fall_mask;
   logic        overrun;

   int checks   = 0;
   int failures = 0;

   int          chg_count = 0;
   int          mask_err  = 0;
   int          reads     = 0;
   logic        prev_read = 1'b0;
   logic [2:0]  last_rise = '0;
   logic [2:0]  last_fall = '0;

   int wait_cyc;
   int hi_cyc;
   int addr_bad;
   int reads_before;

   always #5 clk = ~clk;

   avmm_pio_poll_master #(
      .WIDTH        (3),
      .ADDR_W       (2),
      .PIO_ADDR     (0),
      .POLL_DIV     (8),
      .READ_LATENCY (1),
      .STABLE_CNT   (2)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable        (enable),
      .m_address     (m_address),
      .m_read        (m_read),
      .m_waitrequest (m_waitrequest),
      .m_readdata    (m_readdata),
      .value         (value),
      .value_valid   (value_valid),
      .changed       (changed),
      .rise_mask     (rise_mask),
      .fall_mask     (fall_mask),
      .overrun       (overrun)
   );

   // Event monitor: counts change pulses, read launches and stray masks.
   always @(negedge clk) begin
      if (reset_n) begin
         if (changed) begin
            chg_count = chg_count + 1;
            last_rise = rise_mask;
            last_fall = fall_mask;
         end else if ((rise_mask != 3'b000) || (fall_mask != 3'b000)) begin
            mask_err = mask_err + 1;
         end
         if (m_read && !prev_read)
            reads = reads + 1;
         prev_read = m_read;
      end else begin
         prev_read = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One poll: wait for m_read, stall it for 'stall' cycles, optionally drop
   // enable in WAIT, and return once the filter outputs of this poll are visible.
   task automatic run_poll(input int stall, input bit drop_en,
                           output int wcyc, output int hcyc, output int abad);
      int n;
      int h;
      int bad;
      n = 0;
      h = 0;
      bad = 0;
      m_waitrequest = (stall > 0);
      do begin
         @(negedge clk);
         n++;
      end while (!m_read && (n < 200));
      while (m_read && (h < 100)) begin
         h++;
         if (m_address != 2'd0)
            bad++;
         if (h > stall)
            m_waitrequest = 1'b0;
         @(negedge clk);
      end
      m_waitrequest = 1'b0;
      if (drop_en)
         enable = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      wcyc = n;
      hcyc = h;
      abad = bad;
   endtask

   initial begin
      reset_n       = 1'b0;
      enable        = 1'b1;
      m_waitrequest = 1'b0;
      m_readdata    = 32'hFFFF_FFF5;   // low bits 101, junk above
      repeat (3) @(negedge clk);

      chk("rst_m_read",      {31'd0, m_read},      32'd0);
      chk("rst_value",       {29'd0, value},       32'd0);
      chk("rst_value_valid", {31'd0, value_valid}, 32'd0);
      chk("rst_changed",     {31'd0, changed},     32'd0);
      chk("rst_rise",        {29'd0, rise_mask},   32'd0);
      chk("rst_fall",        {29'd0, fall_mask},   32'd0);
      chk("rst_overrun",     {31'd0, overrun},     32'd0);

      reset_n = 1'b1;

      // First value: two identical polls of 101.
      run_poll(0, 1'b0, wait_cyc, hi_cyc, addr_bad);
      chk("first_read_delay", wait_cyc, 32'd8);
      chk("first_read_hi",    hi_cyc,   32'd1);
      chk("first_not_valid",  {31'd0, value_valid}, 32'd0);
      run_poll(0, 1'b0, wait_cyc, hi_cyc, addr_bad);
      chk("poll_period",      wait_cyc, 32'd5);
      chk("first_value",      {29'd0, value},       32'd5);
      chk("first_valid",      {31'd0, value_valid}, 32'd1);
      chk("first_no_changed", chg_count,            32'd0);

      // Debounced change 101 -> 011.
      m_readdata = 32'h1234_5673;
      run_poll(0, 1'b0, wait_cyc, hi_cyc, addr_bad);
      chk("chg_pending_value", {29'd0, value}, 32'd5);
      chk("chg_pending_count", chg_count,      32'd0);
      run_poll(0, 1'b0, wait_cyc, hi_cyc, addr_bad);
      chk("chg_count", chg_count,           32'd1);
      chk("chg_rise",  {29'd0, last_rise},  32'd2);
      chk("chg_fall",  {29'd0, last_fall},  32'd4);
      chk("chg_value", {29'd0, value},      32'd3);

      // Glitch rejection: 011, 111, 011.
      m_readdata = 32'hABCD_0003;
      run_poll(0, 1'b0, wait_cyc, hi_cyc, addr_bad);
      m_readdata = 32'h0000_0007;
      run_poll(0, 1'b0, wait_cyc, hi_cyc, addr_bad);
      m_readdata = 32'h8000_000B;      // low bits 011, upper bits differ
      run_poll(0, 1'b0, wait_cyc, hi_cyc, addr_bad);
      chk("glitch_count", chg_count,      32'd1);
      chk("glitch_value", {29'd0, value}, 32'd3);

      // Waitrequest stall of 3 cycles.
      run_poll(3, 1'b0, wait_cyc, hi_cyc, addr_bad);
      chk("stall_read_hi",  hi_cyc,   32'd4);
      chk("stall_addr",     addr_bad, 32'd0);
      chk("stall_overrun",  {31'd0, overrun}, 32'd0);
      chk("stall_value",    {29'd0, value},   32'd3);

      // Overrun: 10-cycle stall swallows one tick.
      run_poll(0, 1'b0, wait_cyc, hi_cyc, addr_bad);
      chk("after_stall_gap", wait_cyc, 32'd2);
      run_poll(10, 1'b0, wait_cyc, hi_cyc, addr_bad);
      chk("ovr_read_hi",  hi_cyc, 32'd11);
      chk("ovr_flag",     {31'd0, overrun}, 32'd1);
      reads_before = reads;
      run_poll(0, 1'b0, wait_cyc, hi_cyc, addr_bad);
      chk("ovr_next_gap", wait_cyc, 32'd3);
      chk("ovr_one_read", reads - reads_before, 32'd1);
      chk("ovr_sticky",   {31'd0, overrun}, 32'd1);

      // Enable dropped mid-WAIT: EVAL still accepts 011 -> 110.
      m_readdata = 32'h0000_0006;
      run_poll(0, 1'b0, wait_cyc, hi_cyc, addr_bad);
      run_poll(0, 1'b1, wait_cyc, hi_cyc, addr_bad);
      chk("en_eval_count", chg_count,          32'd2);
      chk("en_eval_rise",  {29'd0, last_rise}, 32'd4);
      chk("en_eval_fall",  {29'd0, last_fall}, 32'd1);
      chk("en_eval_value", {29'd0, value},     32'd6);
      reads_before = reads;
      repeat (30) @(negedge clk);
      chk("en_off_no_read", reads - reads_before, 32'd0);
      enable = 1'b1;
      run_poll(0, 1'b0, wait_cyc, hi_cyc, addr_bad);
      chk("en_restart_delay", wait_cyc, 32'd8);
      chk("mask_idle_zero",   mask_err, 32'd0);

      // Reset asserted mid-REQ.
      m_waitrequest = 1'b1;
      wait_cyc = 0;
      do begin
         @(negedge clk);
         wait_cyc++;
      end while (!m_read && (wait_cyc < 200));
      chk("rreq_in_req", {31'd0, m_read}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rreq_m_read",  {31'd0, m_read},      32'd0);
      chk("rreq_value",   {29'd0, value},       32'd0);
      chk("rreq_valid",   {31'd0, value_valid}, 32'd0);
      chk("rreq_changed", {31'd0, changed},     32'd0);
      chk("rreq_rise",    {29'd0, rise_mask},   32'd0);
      chk("rreq_fall",    {29'd0, fall_mask},   32'd0);
      chk("rreq_overrun", {31'd0, overrun},     32'd0);
      m_waitrequest = 1'b0;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
